song_sequencer: RTL and testbench

SONG_SEQUENCER -- requirements
Module: song_sequencer

---
 rtl/song_sequencer_pkg.sv | 16 +
 rtl/song_rom.sv | 20 ++
 rtl/song_sequencer.sv | 112 +++++++++++
 tb/tb_song_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/song_sequencer_pkg.sv
// song_sequencer_pkg: shared FSM states, default sizes, end marker and ROM song content
package song_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT_DONE, NEXT} state_t;
  localparam int NUM_SONGS_DEF = 4;
  localparam int SONG_LEN_DEF = 32;
  localparam int NOTE_W_DEF = 6;
  localparam int DUR_W_DEF = 6;
  localparam int DUR_END = 0;
  function automatic int rom_note(int s, int i);
    return (s * 11 + i + 1) % 64;
  endfunction
  // song 1 is cut short by an end marker at entry 5; every other entry is a real note
  function automatic int rom_dur(int s, int i);
    return (s == 1 && i >= 5) ? DUR_END : i % 5 + 1;
  endfunction
endpackage

// File: rtl/song_rom.sv
// song_rom: NUM_SONGS*SONG_LEN entries of {note, duration}, registered read with 1-cycle latency
module song_rom
  import song_sequencer_pkg::*;
#(
  parameter int NUM_SONGS = NUM_SONGS_DEF,
  parameter int SONG_LEN = SONG_LEN_DEF,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic                                         clk,
  input  logic [$clog2(NUM_SONGS)+$clog2(SONG_LEN)-1:0] addr,
  output logic [NOTE_W-1:0]                            note,
  output logic [DUR_W-1:0]                             duration
);
  logic [NOTE_W+DUR_W-1:0] mem [NUM_SONGS*SONG_LEN];
  for (genvar g = 0; g < NUM_SONGS * SONG_LEN; g++) begin : g_mem
    assign mem[g] = {NOTE_W'(rom_note(g / SONG_LEN, g % SONG_LEN)), DUR_W'(rom_dur(g / SONG_LEN, g % SONG_LEN))};
  end
  always_ff @(posedge clk) {note, duration} <= mem[addr];
endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: steps through a ROM song note by note, handshaking with a note player.
// Optional LOOP_EN macro adds a loop input that restarts the song at its end instead of idling.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int NUM_SONGS = NUM_SONGS_DEF,
  parameter int SONG_LEN = SONG_LEN_DEF,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic [$clog2(NUM_SONGS)-1:0] song,
  input  logic                         note_done,
`ifdef LOOP_EN
  input  logic                         loop,
`endif
  output logic [NOTE_W-1:0]            note,
  output logic [DUR_W-1:0]             duration,
  output logic                         new_note,
  output logic                         song_done,
  output logic [$clog2(SONG_LEN)-1:0]  index
);
  localparam int SW = $clog2(NUM_SONGS);
  localparam int IW = $clog2(SONG_LEN);
  state_t state, state_n;
  logic [SW-1:0] song_l, song_l_n;
  logic [IW-1:0] index_n;
  logic [NOTE_W-1:0] note_n, rom_note_q;
  logic [DUR_W-1:0] duration_n, rom_dur_q;
  logic end_f, end_f_n, new_note_n, song_done_n, loop_on;
`ifdef LOOP_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif
  song_rom #(.NUM_SONGS(NUM_SONGS), .SONG_LEN(SONG_LEN), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) u_rom (
    .clk(clk),
    .addr({song_l, index}),
    .note(rom_note_q),
    .duration(rom_dur_q)
  );
  always_comb begin
    state_n = state;
    song_l_n = song_l;
    index_n = index;
    end_f_n = end_f;
    note_n = note;
    duration_n = duration;
    new_note_n = 1'b0;
    song_done_n = 1'b0;
    // a song switch outside IDLE restarts the new song from its first note
    if (state != IDLE && song != song_l) begin
      state_n = FETCH;
      song_l_n = song;
      index_n = '0;
      end_f_n = 1'b0;
    end else begin
      case (state)
        IDLE: if (play) begin
          state_n = FETCH;
          song_l_n = song;
          index_n = '0;
          end_f_n = 1'b0;
        end
        FETCH: state_n = LOAD;
        LOAD: if (rom_dur_q != DUR_W'(DUR_END)) begin
          note_n = rom_note_q;
          duration_n = rom_dur_q;
          new_note_n = 1'b1;
          state_n = WAIT_DONE;
        end else begin
          end_f_n = 1'b1;
          state_n = NEXT;
        end
        WAIT_DONE: state_n = note_done ? NEXT : WAIT_DONE;
        NEXT: if (&index || end_f) begin
          song_done_n = 1'b1;
          index_n = '0;
          end_f_n = 1'b0;
          state_n = loop_on ? FETCH : IDLE;
        end else if (play) begin
          index_n = index + 1'b1;
          state_n = FETCH;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      song_l <= '0;
      index <= '0;
      end_f <= 1'b0;
      note <= '0;
      duration <= '0;
      new_note <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state <= state_n;
      song_l <= song_l_n;
      index <= index_n;
      end_f <= end_f_n;
      note <= note_n;
      duration <= duration_n;
      new_note <= new_note_n;
      song_done <= song_done_n;
    end
  end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed scenarios with hand-computed notes for song_sequencer
module tb_song_sequencer;
  logic clk = 1'b0, reset = 1'b0, play = 1'b0, note_done = 1'b0;
  logic [1:0] song = 2'd0;
  logic [5:0] note, duration;
  logic new_note, song_done;
  logic [4:0] index;
`ifdef LOOP_EN
  logic loop = 1'b0;
`endif
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  song_sequencer dut (
    .clk(clk),
    .reset(reset),
    .play(play),
    .song(song),
    .note_done(note_done),
`ifdef LOOP_EN
    .loop(loop),
`endif
    .note(note),
    .duration(duration),
    .new_note(new_note),
    .song_done(song_done),
    .index(index)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic ack;
    note_done = 1'b1;
    step;
    note_done = 1'b0;
  endtask

  task automatic wait_nn(input int max, output int c);
    c = 0;
    do begin
      step;
      c++;
    end while (!new_note && c < max);
  endtask

  task automatic test_reset;
    step;
    step;
    vecs++;
    if ({note, duration, index, new_note, song_done} !== 19'd0) begin
      errs++;
      $display("FAIL reset_outputs got %h want 0", {note, duration, index, new_note, song_done});
    end
    reset = 1'b1;
  endtask

  task automatic test_full_song;
    int c, bad;
    logic [16:0] e;
    song = 2'd0;
    play = 1'b1;
    wait_nn(10, c);
    vecs++;
    if (c !== 3) begin errs++; $display("FAIL first_latency got %0d want 3", c); end
    for (int i = 0; i < 32; i++) begin
      e = {5'(i), 6'((i + 1) % 64), 6'(i % 5 + 1)};
      vecs++;
      if (!new_note || {index, note, duration} !== e) begin
        errs++;
        $display("FAIL song0_note%0d got nn=%b %h want %h", i, new_note, {index, note, duration}, e);
      end
      ack;
      if (i < 31) begin
        wait_nn(10, c);
        vecs++;
        if (c !== 3) begin errs++; $display("FAIL song0_gap%0d got %0d want 3", i, c); end
      end
    end
    c = 0;
    while (!song_done && c < 10) begin step; c++; end
    play = 1'b0;
    vecs++;
    if (c !== 1 || !song_done || new_note) begin
      errs++;
      $display("FAIL song0_done got c=%0d sd=%b nn=%b want 1/1/0", c, song_done, new_note);
    end
    step;
    bad = int'(song_done);
    repeat (5) begin step; bad += int'(new_note) + int'(song_done); end
    vecs++;
    if (bad !== 0) begin errs++; $display("FAIL song0_idle got %0d stray pulses want 0", bad); end
  endtask

  task automatic test_end_marker;
    int c, extra;
    logic [16:0] e;
    song = 2'd1;
    play = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_nn(10, c);
      e = {5'(i), 6'(12 + i), 6'(i % 5 + 1)};
      vecs++;
      if (c !== 3 || {index, note, duration} !== e) begin
        errs++;
        $display("FAIL song1_note%0d got c=%0d %h want 3 %h", i, c, {index, note, duration}, e);
      end
      ack;
    end
    c = 0;
    extra = 0;
    while (!song_done && c < 10) begin step; c++; extra += int'(new_note); end
    play = 1'b0;
    vecs++;
    if (c !== 4 || extra !== 0) begin
      errs++;
      $display("FAIL song1_done got c=%0d extra=%0d want 4/0", c, extra);
    end
  endtask

  task automatic test_pause;
    int c, bad;
    logic [16:0] e;
    song = 2'd2;
    play = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_nn(10, c);
      e = {5'(i), 6'(23 + i), 6'(i % 5 + 1)};
      vecs++;
      if (c !== 3 || {index, note, duration} !== e) begin
        errs++;
        $display("FAIL song2_note%0d got c=%0d %h want 3 %h", i, c, {index, note, duration}, e);
      end
      if (i == 9) play = 1'b0;
      ack;
    end
    bad = 0;
    repeat (20) begin step; bad += int'(new_note); end
    vecs++;
    if (bad !== 0 || index !== 5'd9) begin
      errs++;
      $display("FAIL pause_hold got nn=%0d idx=%0d want 0/9", bad, index);
    end
    play = 1'b1;
    wait_nn(10, c);
    vecs++;
    if (c !== 3 || {index, note, duration} !== {5'd10, 6'd33, 6'd1}) begin
      errs++;
      $display("FAIL pause_resume got c=%0d %h want 3 %h", c, {index, note, duration}, {5'd10, 6'd33, 6'd1});
    end
  endtask

  task automatic test_song_change;
    int c, sd;
    song = 2'd3;
    c = 0;
    sd = 0;
    do begin step; c++; sd += int'(song_done); end while (!new_note && c < 10);
    vecs++;
    if (c > 3 || !new_note || sd !== 0 || {index, note, duration} !== {5'd0, 6'd34, 6'd1}) begin
      errs++;
      $display("FAIL song_change got c=%0d sd=%0d %h want <=3 0 %h", c, sd, {index, note, duration}, {5'd0, 6'd34, 6'd1});
    end
  endtask

  task automatic test_stall;
    int bad;
    logic [16:0] snap;
    snap = {index, note, duration};
    bad = 0;
    repeat (20) begin
      step;
      if ({index, note, duration} !== snap || new_note) bad++;
    end
    vecs++;
    if (bad !== 0) begin errs++; $display("FAIL stall_stable got %0d changes want 0", bad); end
    note_done = 1'b1;
    step;
    step;
    step;
    note_done = 1'b0;
    step;
    vecs++;
    if (!new_note || {index, note, duration} !== {5'd1, 6'd35, 6'd2}) begin
      errs++;
      $display("FAIL stall_resume got nn=%b %h want 1 %h", new_note, {index, note, duration}, {5'd1, 6'd35, 6'd2});
    end
    bad = 0;
    repeat (5) begin step; bad += int'(new_note); end
    vecs++;
    if (bad !== 0 || index !== 5'd1) begin
      errs++;
      $display("FAIL stray_note_done got nn=%0d idx=%0d want 0/1", bad, index);
    end
  endtask

  task automatic test_reset_mid;
    int c;
    reset = 1'b0;
    step;
    vecs++;
    if ({note, duration, index, new_note, song_done} !== 19'd0) begin
      errs++;
      $display("FAIL reset_mid got %h want 0", {note, duration, index, new_note, song_done});
    end
    step;
    reset = 1'b1;
    wait_nn(10, c);
    vecs++;
    if (c !== 3 || {index, note, duration} !== {5'd0, 6'd34, 6'd1}) begin
      errs++;
      $display("FAIL reset_restart got c=%0d %h want 3 %h", c, {index, note, duration}, {5'd0, 6'd34, 6'd1});
    end
`ifdef LOOP_EN
    reset = 1'b0;
    step;
    reset = 1'b1;
    song = 2'd0;
    loop = 1'b1;
    for (int i = 0; i < 32; i++) begin wait_nn(10, c); ack; end
    c = 0;
    while (!song_done && c < 10) begin step; c++; end
    vecs++;
    if (c !== 1) begin errs++; $display("FAIL loop_done got c=%0d want 1", c); end
    wait_nn(10, c);
    vecs++;
    if (c !== 2 || {index, note, duration} !== {5'd0, 6'd1, 6'd1}) begin
      errs++;
      $display("FAIL loop_restart got c=%0d %h want 2 %h", c, {index, note, duration}, {5'd0, 6'd1, 6'd1});
    end
    loop = 1'b0;
`endif
    play = 1'b0;
  endtask

  initial begin
    test_reset;
    test_full_song;
    test_end_marker;
    test_pause;
    test_song_change;
    test_stall;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
